// File: rtl/target_bbox_detect_pkg.sv
// -----------------------------------------------------------------------------
// target_bbox_detect_pkg
// Shared definitions for the red-target bounding-box detector and the VGA
// display driver that consumes its results.
//   - Default image geometry (IMG_W x IMG_H active pixels).
//   - RGB565 field positions (R 15:11, G 10:5, B 4:0).
//   - Coordinate and hit-counter widths.
//   - RED colour constant used by the display overlay.
//   - FSM state encoding.
// -----------------------------------------------------------------------------
package target_bbox_detect_pkg;

    localparam int IMG_W = 640;
    localparam int IMG_H = 480;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int CNT_W = 19;

    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    localparam logic [15:0] RED = 16'hF800;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/target_bbox_detect_rgb565_color_match.sv
// -----------------------------------------------------------------------------
// rgb565_color_match
// Purely combinational red-target classifier for one RGB565 pixel.
// A pixel matches when its red field is at least R_TH and both its green and
// blue fields are at most G_TH / B_TH (strongly red, weakly green/blue).
// Ports:
//   pix    in  16  RGB565 pixel
//   match  out 1   pixel satisfies the red-target threshold
// -----------------------------------------------------------------------------
module rgb565_color_match #(
    parameter logic [4:0] R_TH = 5'd20,
    parameter logic [5:0] G_TH = 6'd24,
    parameter logic [4:0] B_TH = 5'd12
) (
    input  logic [15:0] pix,
    output logic        match
);
    import target_bbox_detect_pkg::*;

    logic [4:0] r_field;
    logic [5:0] g_field;
    logic [4:0] b_field;

    assign r_field = pix[R_HI:R_LO];
    assign g_field = pix[G_HI:G_LO];
    assign b_field = pix[B_HI:B_LO];

    assign match = (r_field >= R_TH) && (g_field <= G_TH) && (b_field <= B_TH);

endmodule

// File: rtl/target_bbox_detect.sv
// -----------------------------------------------------------------------------
// target_bbox_detect
// Scans an RGB565 pixel stream, classifies each pixel against a red-target
// threshold and tracks the bounding box of matching pixels over one frame.
// At end of frame the box edges and its centre are published for the display
// driver, which overlays them in red.
// Ports:
//   sclk          in  1   system clock
//   s_rst_n       in  1   asynchronous active-low reset
//   pix_sof       in  1   start of frame; marks the same-cycle pixel as (0,0)
//   pix_valid     in  1   pixel strobe
//   pix_data      in  16  RGB565 pixel
//   x_min/x_max   out 11  left/right edge of last valid box
//   y_min/y_max   out 10  top/bottom edge of last valid box
//   x_coor        out 11  box centre x
//   y_coor        out 10  box centre y
//   target_found  out 1   last completed frame had at least MIN_PIX matches
//   frame_done    out 1   one-cycle pulse when the outputs update
// -----------------------------------------------------------------------------
module target_bbox_detect #(
    parameter int          IMG_W   = target_bbox_detect_pkg::IMG_W,
    parameter int          IMG_H   = target_bbox_detect_pkg::IMG_H,
    parameter logic [4:0]  R_TH    = 5'd20,
    parameter logic [5:0]  G_TH    = 6'd24,
    parameter logic [4:0]  B_TH    = 5'd12,
    parameter logic [18:0] MIN_PIX = 19'd64
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        pix_sof,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic [10:0] x_min,
    output logic [10:0] x_max,
    output logic [9:0]  y_min,
    output logic [9:0]  y_max,
    output logic [10:0] x_coor,
    output logic [9:0]  y_coor,
    output logic        target_found,
    output logic        frame_done
);
    import target_bbox_detect_pkg::*;

    localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
    localparam logic [X_W-1:0]   X_ONE   = X_W'(1);
    localparam logic [Y_W-1:0]   Y_ONE   = Y_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Hit counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

    // Centre coordinates: sum one bit wider than the operands, then halve.
    function automatic logic [X_W-1:0] mid_x(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
        logic [X_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[X_W:1];
    endfunction

    function automatic logic [Y_W-1:0] mid_y(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
        logic [Y_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[Y_W:1];
    endfunction

    state_t state;
    state_t state_nxt;
    logic   publish;

    logic           start;
    logic           accept;
    logic           frame_end;
    logic           match;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;

    logic             any_hit;
    logic [CNT_W-1:0] hit_cnt;
    logic [X_W-1:0]   trk_x_min;
    logic [X_W-1:0]   trk_x_max;
    logic [Y_W-1:0]   trk_y_min;
    logic [Y_W-1:0]   trk_y_max;

    rgb565_color_match #(
        .R_TH (R_TH),
        .G_TH (G_TH),
        .B_TH (B_TH)
    ) u_color_match (
        .pix   (pix_data),
        .match (match)
    );

    // A start-of-frame pixel is accepted in any state and restarts the frame;
    // otherwise pixels only count while scanning.
    assign start     = pix_valid & pix_sof;
    assign accept    = start | (pix_valid & (state == ST_SCAN));
    assign cur_x     = start ? '0 : x_cnt;
    assign cur_y     = start ? '0 : y_cnt;
    assign frame_end = accept && (cur_x == X_LAST) && (cur_y == Y_LAST);

    // ---- FSM: state register ----
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (frame_end) begin
                    state_nxt = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                state_nxt = start ? ST_SCAN : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        publish = (state == ST_PUBLISH);
    end

    // ---- Pixel position counters ----
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (accept) begin
            if (cur_x == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (cur_y == Y_LAST) ? '0 : cur_y + Y_ONE;
            end else begin
                x_cnt <= cur_x + X_ONE;
                y_cnt <= cur_y;
            end
        end
    end

    // ---- Bounding-box tracker ----
    // On a restart the old box is discarded; the restart pixel itself may
    // already be the first match of the new frame.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            any_hit   <= 1'b0;
            hit_cnt   <= '0;
            trk_x_min <= '0;
            trk_x_max <= '0;
            trk_y_min <= '0;
            trk_y_max <= '0;
        end else if (accept) begin
            if (match) begin
                any_hit <= 1'b1;
                hit_cnt <= sat_inc(start ? '0 : hit_cnt);
                if (start || !any_hit) begin
                    trk_x_min <= cur_x;
                    trk_x_max <= cur_x;
                    trk_y_min <= cur_y;
                    trk_y_max <= cur_y;
                end else begin
                    if (cur_x < trk_x_min) trk_x_min <= cur_x;
                    if (cur_x > trk_x_max) trk_x_max <= cur_x;
                    if (cur_y < trk_y_min) trk_y_min <= cur_y;
                    if (cur_y > trk_y_max) trk_y_max <= cur_y;
                end
            end else if (start) begin
                any_hit <= 1'b0;
                hit_cnt <= '0;
            end
        end
    end

    // ---- Publish stage: outputs change only here ----
    // A frame below MIN_PIX keeps the previous box so the overlay does not
    // jump to a noise-driven box.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            x_min        <= '0;
            x_max        <= '0;
            y_min        <= '0;
            y_max        <= '0;
            x_coor       <= '0;
            y_coor       <= '0;
            target_found <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= publish;
            if (publish) begin
                if (hit_cnt >= MIN_PIX) begin
                    x_min        <= trk_x_min;
                    x_max        <= trk_x_max;
                    y_min        <= trk_y_min;
                    y_max        <= trk_y_max;
                    x_coor       <= mid_x(trk_x_min, trk_x_max);
                    y_coor       <= mid_y(trk_y_min, trk_y_max);
                    target_found <= 1'b1;
                end else begin
                    target_found <= 1'b0;
                end
            end
        end
    end

endmodule
